mips_divider: RTL
=================

# mips_divider

Multi-cycle restoring divider for the MIPS datapath, executing DIV and DIVU. It is the inverse counterpart of the ripple adder chain: it repeatedly subtracts and restores one quotient bit per cycle. It sits beside the ALU in the execute stage and writes its results to the HI (remainder) and LO (quotient) registers. The pipeline stalls while `busy` is high.

## Interface
Parameters:
- `WIDTH`, default 32: operand width in bits. Must be at least 2.

Ports:
- `clk`, input, 1: the single clock. Every flop updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a division. Sampled only in IDLE.
- `is_signed`, input, 1: 1 selects DIV (two's complement); 0 selects DIVU. Sampled with `start`.
- `dividend`, input, WIDTH: numerator. Sampled with `start`.
- `divisor`, input, WIDTH: denominator. Sampled with `start`.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done` has pulsed.
- `done`, output, 1: one-cycle pulse. Results are valid while it is high.
- `quotient`, output, WIDTH: goes to LO. Holds its value until the next `done`.
- `remainder`, output, WIDTH: goes to HI. Holds its value until the next `done`.
- `div_by_zero`, output, 1: flag for the last completed operation. Updated at each `done`.

## Operation
- States are IDLE, RUN, FIX and DONE.
- IDLE with `start`=1:
  - Latch the operand magnitudes. For signed operands the magnitude is the two's-complement negation when the MSB is 1. For unsigned operands it is the raw value.
  - Latch the quotient sign (dividend MSB XOR divisor MSB), the remainder sign (dividend MSB) and the zero-divisor flag. Signs are 0 when `is_signed`=0.
  - Clear the partial remainder (WIDTH+1 bits) and the step counter. Go to RUN.
- RUN, one step per cycle:
  - Shift {partial remainder, quotient register} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder, using a WIDTH+1-bit subtraction.
  - If the result is non-negative, keep it and set the quotient LSB to 1. Otherwise keep the old value (restore) and set the quotient LSB to 0.
  - After exactly WIDTH steps, go to FIX.
- FIX:
  - Negate the quotient if its sign bit is set, and negate the remainder if its sign bit is set.
  - Register the results to `quotient`, `remainder` and `div_by_zero`. Go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Divide by zero:
  - The unit still runs the full sequence.
  - Required result: `quotient` = all ones (unsigned view), `remainder` = `dividend` unchanged, `div_by_zero`=1.
  - Force this result in FIX regardless of `is_signed`.
- Signed overflow (most-negative / −1): `quotient` = 1 followed by WIDTH−1 zeros (0x80000000 at WIDTH=32), `remainder`=0, `div_by_zero`=0. Modular negation produces this naturally.
- `start` during RUN, FIX or DONE is ignored. The request is not queued and the operand inputs are not resampled.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset value of every output is 0: `busy`, `done`, `quotient`, `remainder` and `div_by_zero`. The state resets to IDLE and the counter to 0.
- Reset asserted mid-operation:
  - Return to IDLE immediately, asynchronously.
  - The in-flight operation is discarded with no `done` pulse.
  - The result registers clear to 0.
- Latency: the edge that samples `start` is edge 0. `busy` rises after edge 0. `done` is high in the cycle after edge WIDTH+2, which is 34 cycles at WIDTH=32.
- `busy` and `done` are high together in the DONE cycle. `busy` falls with `done`.
- In the cycle after `done`, a new `start` is accepted (state is IDLE). Back-to-back throughput is one operation per WIDTH+3 cycles.
- Latency is fixed and data-independent, including for zero divisors.

## Test plan
- DIVU, `dividend`=100, `divisor`=7, `start` pulse -> `done` 34 cycles later with `quotient`=14, `remainder`=2, `div_by_zero`=0, and `busy` high for cycles 1 through 34.
- DIV, `dividend`=−7 (0xFFFFFFF9), `divisor`=2 -> `quotient`=−3 (0xFFFFFFFD), `remainder`=−1 (0xFFFFFFFF). Repeat with 7/−2 -> `quotient`=−3, `remainder`=1.
- DIV with 0x80000000 / 0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0. DIVU with 0xFFFFFFFF / 1 -> `quotient`=0xFFFFFFFF, `remainder`=0.
- DIVU with 12345 / 0 -> `quotient`=0xFFFFFFFF, `remainder`=12345, `div_by_zero`=1, `done` still at cycle 34. A following 9/3 clears `div_by_zero` to 0 with `quotient`=3.
- `start` re-pulsed with different operands at cycles 5 and 33 -> ignored, and the first result is unchanged. A `start` in the cycle after `done` -> accepted, with its `done` 34 cycles later.
- `reset` asserted at cycle 10 of an operation -> all outputs 0 immediately and no `done` pulse. A new operation after reset completes correctly.
- Randomized signed and unsigned operands compared against a reference model. The model truncates the quotient toward zero, gives the remainder the dividend's sign, and applies the zero-divisor rule above.

Source files
------------

// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for DIV / DIVU. Produces one quotient bit per
// cycle. The remainder goes to HI and the quotient goes to LO. The latency is
// fixed at WIDTH+3 cycles from the accepting edge to the end of the done pulse.
module mips_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fix_ph_q, fix_ph_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             dbz_q, dbz_d;
    logic             load_out;

    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             div_by_zero_q;

    // The partial remainder is always below the divisor, so only WIDTH bits
    // are stored. The WIDTH+1-bit working value exists only during the shift
    // and trial subtraction, and its top bit is the sign of the trial result.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_neg, rem_neg;

    assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, dvs_q};
    assign quo_neg = -quo_q;
    assign rem_neg = -rem_q;

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

    // Next-state logic for the control FSM and the datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fix_ph_d = fix_ph_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        dbz_d    = dbz_q;
        load_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvs_d    = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
                    quo_d    = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                    rem_d    = '0;
                    cnt_d    = '0;
                    fix_ph_d = 1'b0;
                    qsign_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rsign_d  = is_signed & dividend[WIDTH-1];
                    dbz_d    = (divisor == '0);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // A negative trial result means restore, which keeps the
                // shifted remainder unchanged.
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Phase 0 applies the sign correction in place. Phase 1
                // publishes the results. A zero divisor already leaves the
                // dividend magnitude in the remainder, so restoring its sign
                // returns the original dividend. Only the quotient is forced.
                if (!fix_ph_q) begin
                    if (dbz_q) begin
                        quo_d = '1;
                    end else if (qsign_q) begin
                        quo_d = quo_neg;
                    end
                    if (rsign_q) begin
                        rem_d = rem_neg;
                    end
                    fix_ph_d = 1'b1;
                end else begin
                    load_out = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers. Reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fix_ph_q <= 1'b0;
            dvs_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fix_ph_q <= fix_ph_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            dbz_q    <= dbz_d;
        end
    end

    // Result registers. They change only on entry to DONE and hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else if (load_out) begin
            quotient_q    <= quo_q;
            remainder_q   <= rem_q;
            div_by_zero_q <= dbz_q;
        end
    end

endmodule
